// File: rtl/ceespu_mem_arbiter.sv
// ceespu_mem_arbiter
//
// Shares the single port of the ceespu data RAM between the CPU execute stage
// and an external requester (bootloader / debug / DMA). The CPU normally wins;
// a saturating starvation counter forces one external slot after MAX_WAIT
// consecutive denied cycles, stalling the CPU for that one cycle. Read data
// from the synchronous-read RAM is steered back to whichever side issued the
// read one cycle earlier.
//
// Handshake: I_ext_req is held high until O_ext_gnt is seen in the same cycle;
// the access is performed in that cycle. For an external read, O_ext_rvalid
// and O_ext_rdata are valid exactly one cycle after the grant. A CPU access
// is performed in any cycle where I_cpu_memE is high and O_cpu_stall is low;
// CPU load data appears on O_cpu_rdata in the following cycle.
//
// Ports:
//   I_clk, I_rst                 clock, synchronous active-high reset
//   I_cpu_memE/_write/_byteWe    CPU access request, write flag, lane enables
//   I_cpu_addr, I_cpu_wdata      CPU byte address, store data
//   O_cpu_rdata, O_cpu_stall     CPU load data, stall
//   I_ext_req/_we/_addr/_wdata   external request, lane enables (0 = read),
//                                word address, write data
//   O_ext_gnt, O_ext_rvalid      external grant, read data valid
//   O_ext_rdata                  external read data
//   O_ram_en/_we/_addr/_wdata    RAM port controls
//   I_ram_rdata                  RAM read data (1-cycle latency)

module ceespu_mem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 3
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_cpu_memE,
  input  logic              I_cpu_write,
  input  logic [3:0]        I_cpu_byteWe,
  input  logic [31:0]       I_cpu_addr,
  input  logic [31:0]       I_cpu_wdata,
  output logic [31:0]       O_cpu_rdata,
  output logic              O_cpu_stall,
  input  logic              I_ext_req,
  input  logic [3:0]        I_ext_we,
  input  logic [ADDR_W-1:0] I_ext_addr,
  input  logic [31:0]       I_ext_wdata,
  output logic              O_ext_gnt,
  output logic              O_ext_rvalid,
  output logic [31:0]       O_ext_rdata,
  output logic              O_ram_en,
  output logic [3:0]        O_ram_we,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [31:0]       O_ram_wdata,
  input  logic [31:0]       I_ram_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Who issued the read whose data is on I_ram_rdata this cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_EXT  = 2'd2
  } rd_owner_e;

  rd_owner_e  rd_owner_q, rd_owner_d;
  logic [3:0] starve_q, starve_d;

  logic ext_win;
  logic cpu_rd;

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^{I_cpu_addr[31:ADDR_W+2], I_cpu_addr[1:0]};

  always_comb begin
    ext_win = I_ext_req && (!I_cpu_memE || (starve_q == MAX_WAIT_C));
    cpu_rd  = I_cpu_memE && !I_cpu_write && !ext_win;
  end

  // RAM port mux and handshake outputs.
  always_comb begin
    O_ext_gnt   = ext_win;
    O_cpu_stall = I_cpu_memE && ext_win;
    if (ext_win) begin
      O_ram_en    = 1'b1;
      O_ram_we    = I_ext_we;
      O_ram_addr  = I_ext_addr;
      O_ram_wdata = I_ext_wdata;
    end else begin
      O_ram_en    = I_cpu_memE;
      // byteWe is don't-care on CPU reads; gate it so the RAM never sees X.
      O_ram_we    = (I_cpu_memE && I_cpu_write) ? I_cpu_byteWe : 4'b0000;
      O_ram_addr  = I_cpu_addr[ADDR_W+1:2];
      O_ram_wdata = I_cpu_wdata;
    end
  end

  // Starvation counter and read-owner next state.
  always_comb begin
    starve_d   = 4'd0;
    rd_owner_d = RD_NONE;
    if (!I_rst) begin
      if (I_ext_req && !ext_win) begin
        starve_d = (starve_q < MAX_WAIT_C) ? (starve_q + 4'd1) : starve_q;
      end
      if (ext_win && (I_ext_we == 4'b0000)) begin
        rd_owner_d = RD_EXT;
      end else if (cpu_rd) begin
        rd_owner_d = RD_CPU;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      starve_q   <= 4'd0;
      rd_owner_q <= RD_NONE;
    end else begin
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Both sides see the RAM data; only the owner treats it as valid.
  always_comb begin
    O_ext_rvalid = (rd_owner_q == RD_EXT);
    O_ext_rdata  = I_ram_rdata;
    O_cpu_rdata  = I_ram_rdata;
  end

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// Testbench for ceespu_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (denied-cycle count, memory image, pending read owner).

module tb_ceespu_mem_arbiter;

  localparam int ADDR_W   = 12;
  localparam int MAX_WAIT = 3;
  localparam int DEPTH    = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cpu_memE, cpu_write;
  logic [3:0]        cpu_byteWe;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              ext_req;
  logic [3:0]        ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_wdata, ext_rdata;
  logic              ext_gnt, ext_rvalid;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'h0;

  ceespu_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_cpu_memE(cpu_memE), .I_cpu_write(cpu_write), .I_cpu_byteWe(cpu_byteWe),
    .I_cpu_addr(cpu_addr), .I_cpu_wdata(cpu_wdata),
    .O_cpu_rdata(cpu_rdata), .O_cpu_stall(cpu_stall),
    .I_ext_req(ext_req), .I_ext_we(ext_we), .I_ext_addr(ext_addr),
    .I_ext_wdata(ext_wdata),
    .O_ext_gnt(ext_gnt), .O_ext_rvalid(ext_rvalid), .O_ext_rdata(ext_rdata),
    .O_ram_en(ram_en), .O_ram_we(ram_we), .O_ram_addr(ram_addr),
    .O_ram_wdata(ram_wdata), .I_ram_rdata(ram_rdata)
  );

  // ---------------- RAM (read-first, registered output) ----------------
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] model_mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i]   = 32'h1000_0000 + 32'(i);
      model_mem[i] = 32'h1000_0000 + 32'(i);
    end
  end

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_wait: consecutive cycles the external side has been refused.
  // m_own : 0 none, 1 CPU, 2 EXT owns the data arriving this cycle.
  int          m_wait = 0;
  int          m_own  = 0;
  logic [31:0] m_data = 32'h0;
  bit          model_live = 0;

  function automatic bit model_ext_wins();
    return ext_req && (!cpu_memE || (m_wait >= MAX_WAIT));
  endfunction

  always @(posedge clk) begin
    bit win;
    logic [ADDR_W-1:0] ca;
    win = model_ext_wins();
    ca  = cpu_addr[ADDR_W+1:2];
    if (rst) begin
      m_own  = 0;
      m_wait = 0;
      model_live = 1;
    end else begin
      if (win && ext_we == 4'b0) begin
        m_own = 2; m_data = model_mem[ext_addr];
      end else if (cpu_memE && !cpu_write && !win) begin
        m_own = 1; m_data = model_mem[ca];
      end else begin
        m_own = 0;
      end
      if (ext_req && !win) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : m_wait;
      else                 m_wait = 0;
    end
    // Memory image follows whichever access the rules say happened.
    if (win) begin
      for (int b = 0; b < 4; b++)
        if (ext_we[b]) model_mem[ext_addr][b*8 +: 8] = ext_wdata[b*8 +: 8];
    end else if (cpu_memE && cpu_write) begin
      for (int b = 0; b < 4; b++)
        if (cpu_byteWe[b]) model_mem[ca][b*8 +: 8] = cpu_wdata[b*8 +: 8];
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      bit win;
      logic [3:0] exp_we;
      win = model_ext_wins();
      exp_we = win ? ext_we : ((cpu_memE && cpu_write) ? cpu_byteWe : 4'b0);
      chk("m_gnt",    32'(ext_gnt),   32'(win));
      chk("m_stall",  32'(cpu_stall), 32'(cpu_memE && win));
      chk("m_ram_en", 32'(ram_en),    32'(win || cpu_memE));
      chk("m_ram_we", 32'(ram_we),    32'(exp_we));
      chk("m_ram_addr", 32'(ram_addr), 32'(win ? ext_addr : cpu_addr[ADDR_W+1:2]));
      chk("m_ram_wdata", ram_wdata, win ? ext_wdata : cpu_wdata);
      chk("m_rvalid", 32'(ext_rvalid), 32'(m_own == 2));
      if (m_own == 2) chk("m_ext_rdata", ext_rdata, m_data);
      if (m_own == 1) chk("m_cpu_rdata", cpu_rdata, m_data);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic en, input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
    cpu_memE = en; cpu_write = wr; cpu_byteWe = be; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic [3:0] we,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit gnt_seen;

    // Reset with both sides requesting: counting must stay suppressed.
    rst = 1'b1;
    set_cpu(1'b1, 1'b0, 4'b0, 32'h10, 32'h0);
    set_ext(1'b1, 4'b0, 12'd7, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // c0: first CPU read of 0x10 after reset, CPU wins.
    @(negedge clk);
    chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
    chk("rst_gnt",    32'(ext_gnt),    32'd0);
    chk("rst_stall",  32'(cpu_stall),  32'd0);
    chk("rst_addr",   32'(ram_addr),   32'd4);
    next_cycle();
    // c1..c7: contention, forced ext slot every 4th cycle.
    @(negedge clk);
    chk("c1_cpu_rdata", cpu_rdata, 32'h1000_0004);
    chk("c1_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    @(negedge clk); chk("c2_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("c3_gnt",   32'(ext_gnt),   32'd1);
    chk("c3_stall", 32'(cpu_stall), 32'd1);
    chk("c3_addr",  32'(ram_addr),  32'd7);
    next_cycle();
    @(negedge clk);
    chk("c4_gnt",    32'(ext_gnt),    32'd0);
    chk("c4_stall",  32'(cpu_stall),  32'd0);
    chk("c4_rvalid", 32'(ext_rvalid), 32'd1);
    chk("c4_rdata",  ext_rdata,       32'h1000_0007);
    next_cycle();
    @(negedge clk); chk("c5_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    @(negedge clk); chk("c6_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    @(negedge clk); chk("c7_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();

    // c8: both idle, read from c7 still returns.
    set_cpu(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
    set_ext(1'b0, 4'b0, 12'd0, 32'h0);
    @(negedge clk);
    chk("c8_rvalid", 32'(ext_rvalid), 32'd1);
    chk("c8_gnt",    32'(ext_gnt),    32'd0);
    next_cycle();

    // c9: ext-only write, c10: ext read back.
    set_ext(1'b1, 4'hF, 12'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_gnt",    32'(ext_gnt),    32'd1);
    chk("wr_ram_we", 32'(ram_we),     32'hF);
    chk("wr_rvalid", 32'(ext_rvalid), 32'd0);
    next_cycle();
    set_ext(1'b1, 4'h0, 12'd5, 32'h0);
    @(negedge clk); chk("rd_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();

    // c11: read data returns; CPU read with don't-care lane enables.
    set_ext(1'b0, 4'h0, 12'd0, 32'h0);
    set_cpu(1'b1, 1'b0, 4'bxxxx, 32'h14, 32'h0);
    @(negedge clk);
    chk("rd_rvalid", 32'(ext_rvalid), 32'd1);
    chk("rd_rdata",  ext_rdata,       32'hDEAD_BEEF);
    chk("cpu_rd_we", 32'(ram_we),     32'd0);
    chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    next_cycle();

    // c12..c14: ext denied twice, then drops; c15..c18 needs 3 fresh denials.
    set_ext(1'b1, 4'h0, 12'd9, 32'h0);
    @(negedge clk);
    chk("cpu_rdata_x", cpu_rdata, 32'hDEAD_BEEF);
    chk("w1_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    @(negedge clk); chk("w2_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    ext_req = 1'b0;
    @(negedge clk); chk("drop_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    ext_req = 1'b1;
    @(negedge clk); chk("re1_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    @(negedge clk); chk("re2_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    @(negedge clk); chk("re3_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("re4_gnt",   32'(ext_gnt),   32'd1);
    chk("re4_stall", 32'(cpu_stall), 32'd1);
    next_cycle();

    // Reset coinciding with an ext read grant: data discarded.
    set_cpu(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
    set_ext(1'b1, 4'h0, 12'd3, 32'h0);
    rst = 1'b1;
    @(negedge clk); chk("rg_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();
    rst = 1'b0;
    ext_req = 1'b0;
    @(negedge clk); chk("rg_rvalid", 32'(ext_rvalid), 32'd0);
    next_cycle();
    // Reset in the cycle after an ext read grant.
    ext_req = 1'b1;
    @(negedge clk); chk("ra_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();
    ext_req = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk); chk("ra_rvalid", 32'(ext_rvalid), 32'd0);
    next_cycle();

    // Randomized traffic; the ext request is held until granted.
    gnt_seen = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              4'($urandom), {18'($urandom), 5'($urandom_range(0, 31)),
              7'($urandom), 2'($urandom)}, $urandom);
      if (!ext_req || gnt_seen)
        set_ext($urandom_range(0, 2) != 0,
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                12'($urandom_range(0, 31)), $urandom);
      @(negedge clk);
      gnt_seen = ext_gnt;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
